garegga_extratext_ram: RTL

CPU-side owner of the extra-text layer memories: text VRAM (4096×16), text select RAM (256×16) and text scroll RAM (256×16). Accepts 68000-style asynchronous bus cycles on port A, synchronises them into CLK96, decodes them and performs byte-lane writes and word reads with DTACK handshaking. Port B serves the extra-text line renderer's read-only address/data buses at a fixed 2-cycle latency.

---
 rtl/garegga_extratext_ram.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/garegga_extratext_ram.sv
// garegga_extratext_ram
//
// CPU-side owner of the extra-text layer memories:
//   text VRAM        4096 x 16   (CPU_A[13:12] = 00, index A[11:0])
//   text select RAM   256 x 16   (CPU_A[13:12] = 01, index A[7:0])
//   text scroll RAM   256 x 16   (CPU_A[13:12] = 10, index A[7:0], mirrors)
//   CPU_A[13:12] = 11 is unmapped: writes dropped, reads return 16'hFFFF,
//   both acknowledged.
//
// Port A is a 68000-style asynchronous bus, synchronised into CLK96.
// Port B is the line renderer's read-only side with a fixed 2-cycle latency.
//
// Ports
//   CLK96, RESET96 (async, active-high)
//   CPU_AS_N, CPU_UDS_N, CPU_LDS_N, CPU_RW, CPU_CS, CPU_A[13:0], CPU_DIN[15:0]
//   CPU_DOUT[15:0]   read data, held until the next read completes
//   CPU_DTACK_N      acknowledge, active-low
//   TEXTVRAM_ADDR/DATA, TEXTSELECT_ADDR/DATA, TEXTSCROLL_ADDR/DATA  (port B)
//   BUSY             high while the clear sequence runs
//   DBG_STATE[2:0]   current FSM state (0 IDLE, 1 DECODE, 2 RWAIT, 3 ACK, 4 CLEAR)
//
// Build option
//   EXTRATEXT_CLEAR_EN : when defined, every word is zeroed after reset
//   (4096 cycles, BUSY high, CPU cycles held off until done).
//
// Handshake: a CPU cycle starts when the synchronised AS is low with CS high
// and at least one data strobe active. CPU_DTACK_N is driven low once the
// write is committed or the read data is on CPU_DOUT, and stays low until the
// synchronised AS returns high; AS must then stay high for at least 3 CLK96
// cycles before the next cycle begins.

module garegga_extratext_ram (
   input  logic        CLK96,
   input  logic        RESET96,
   input  logic        CPU_AS_N,
   input  logic        CPU_UDS_N,
   input  logic        CPU_LDS_N,
   input  logic        CPU_RW,
   input  logic        CPU_CS,
   input  logic [13:0] CPU_A,
   input  logic [15:0] CPU_DIN,
   output logic [15:0] CPU_DOUT,
   output logic        CPU_DTACK_N,
   input  logic [11:0] TEXTVRAM_ADDR,
   output logic [15:0] TEXTVRAM_DATA,
   input  logic [7:0]  TEXTSELECT_ADDR,
   output logic [15:0] TEXTSELECT_DATA,
   input  logic [7:0]  TEXTSCROLL_ADDR,
   output logic [15:0] TEXTSCROLL_DATA,
   output logic        BUSY,
   output logic [2:0]  DBG_STATE
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_RWAIT  = 3'd2,
      S_ACK    = 3'd3,
      S_CLEAR  = 3'd4
   } state_t;

   state_t state;

   // two-flop synchronisers for the asynchronous strobes
   logic as_s1, as_s2, uds_s1, uds_s2, lds_s1, lds_s2, cs_s1, cs_s2;

   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96) begin
         as_s1  <= 1'b1;
         as_s2  <= 1'b1;
         uds_s1 <= 1'b1;
         uds_s2 <= 1'b1;
         lds_s1 <= 1'b1;
         lds_s2 <= 1'b1;
         cs_s1  <= 1'b0;
         cs_s2  <= 1'b0;
      end else begin
         as_s1  <= CPU_AS_N;
         as_s2  <= as_s1;
         uds_s1 <= CPU_UDS_N;
         uds_s2 <= uds_s1;
         lds_s1 <= CPU_LDS_N;
         lds_s2 <= lds_s1;
         cs_s1  <= CPU_CS;
         cs_s2  <= cs_s1;
      end
   end

   // latched bus cycle
   logic        rw_l;
   logic [13:0] a_l;
   logic [15:0] din_l;
   logic        wait_cnt;
   logic [15:0] rd_mux_q;

`ifdef EXTRATEXT_CLEAR_EN
   logic [11:0] clr_cnt;
   logic        busy_q;
   assign BUSY = busy_q;
`else
   assign BUSY = 1'b0;
`endif

   assign DBG_STATE = state;

   // port-A write/read address and byte enables
   logic [11:0] wa_vram;
   logic [7:0]  wa_small;
   logic [15:0] wdata;
   logic [1:0]  we_vram, we_sel, we_scr;
   logic [1:0]  lanes;

   always_comb begin
      wa_vram  = a_l[11:0];
      wa_small = a_l[7:0];
      wdata    = din_l;
      we_vram  = 2'b00;
      we_sel   = 2'b00;
      we_scr   = 2'b00;
      lanes    = {~uds_s2, ~lds_s2};
      // one-cycle write pulse in DECODE; an AS already released aborts it
      if (state == S_DECODE && !as_s2 && !rw_l) begin
         case (a_l[13:12])
            2'b00:   we_vram = lanes;
            2'b01:   we_sel  = lanes;
            2'b10:   we_scr  = lanes;
            default: ;
         endcase
      end
`ifdef EXTRATEXT_CLEAR_EN
      if (state == S_CLEAR) begin
         wa_vram  = clr_cnt;
         wa_small = clr_cnt[7:0];
         wdata    = 16'h0000;
         we_vram  = 2'b11;
         we_sel   = 2'b11;
         we_scr   = 2'b11;
      end
`endif
   end

   // memories: port A read/write, port B registered read with an extra output
   // stage; reads see the old word when a write hits the same address.
   logic [15:0] vram [0:4095];
   logic [15:0] sel_ram [0:255];
   logic [15:0] scr_ram [0:255];
   logic [15:0] qa_vram, qa_sel, qa_scr;
   logic [15:0] qb_vram, qb_sel, qb_scr;
   logic [1:0]  rd_region_q;

   always_ff @(posedge CLK96) begin
      if (we_vram[1]) vram[wa_vram][15:8] <= wdata[15:8];
      if (we_vram[0]) vram[wa_vram][7:0]  <= wdata[7:0];
      qa_vram       <= vram[wa_vram];
      qb_vram       <= vram[TEXTVRAM_ADDR];
      TEXTVRAM_DATA <= qb_vram;
   end

   always_ff @(posedge CLK96) begin
      if (we_sel[1]) sel_ram[wa_small][15:8] <= wdata[15:8];
      if (we_sel[0]) sel_ram[wa_small][7:0]  <= wdata[7:0];
      qa_sel          <= sel_ram[wa_small];
      qb_sel          <= sel_ram[TEXTSELECT_ADDR];
      TEXTSELECT_DATA <= qb_sel;
   end

   always_ff @(posedge CLK96) begin
      if (we_scr[1]) scr_ram[wa_small][15:8] <= wdata[15:8];
      if (we_scr[0]) scr_ram[wa_small][7:0]  <= wdata[7:0];
      qa_scr          <= scr_ram[wa_small];
      qb_scr          <= scr_ram[TEXTSCROLL_ADDR];
      TEXTSCROLL_DATA <= qb_scr;
   end

   // port-A read data stage, aligned with the port-B output register
   always_ff @(posedge CLK96) begin
      rd_region_q <= a_l[13:12];
      case (rd_region_q)
         2'b00:   rd_mux_q <= qa_vram;
         2'b01:   rd_mux_q <= qa_sel;
         2'b10:   rd_mux_q <= qa_scr;
         default: rd_mux_q <= 16'hFFFF;
      endcase
   end

   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96) begin
`ifdef EXTRATEXT_CLEAR_EN
         state   <= S_CLEAR;
         clr_cnt <= 12'd0;
         busy_q  <= 1'b1;
`else
         state   <= S_IDLE;
`endif
         CPU_DTACK_N <= 1'b1;
         CPU_DOUT    <= 16'h0000;
         rw_l        <= 1'b1;
         a_l         <= 14'd0;
         din_l       <= 16'h0000;
         wait_cnt    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // RW/A/DIN are stable while AS is low, so they are captured on
               // the edge that enters DECODE and are held through the cycle.
               if (!as_s2 && cs_s2 && (!uds_s2 || !lds_s2)) begin
                  state <= S_DECODE;
                  rw_l  <= CPU_RW;
                  a_l   <= CPU_A;
                  din_l <= CPU_DIN;
               end
            end
            S_DECODE: begin
               if (as_s2) begin
                  state <= S_IDLE;
               end else if (rw_l) begin
                  state    <= S_RWAIT;
                  wait_cnt <= 1'b0;
               end else begin
                  state       <= S_ACK;
                  CPU_DTACK_N <= 1'b0;
               end
            end
            S_RWAIT: begin
               if (wait_cnt) begin
                  CPU_DOUT    <= rd_mux_q;
                  CPU_DTACK_N <= 1'b0;
                  state       <= S_ACK;
               end else begin
                  wait_cnt <= 1'b1;
               end
            end
            S_ACK: begin
               if (as_s2) begin
                  CPU_DTACK_N <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            S_CLEAR: begin
`ifdef EXTRATEXT_CLEAR_EN
               clr_cnt <= clr_cnt + 12'd1;
               if (clr_cnt == 12'd4095) begin
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end
`else
               state <= S_IDLE;
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
